interp_gain_ramp: RTL and testbench

- Sequences gain changes into the interpolator's mantissa/exponent gain stage, so a software write never causes a gain step mid-stream.
- Takes the target mantissa/exponent committed by the bus register block and ramps the active mantissa toward the target in programmable steps, paced by the sample clock enable.
- An exponent change is applied only at zero gain: ramp down to 0, swap the exponent, then ramp up to the target.
- Sits between the interpolator register block and the interpolator datapath gain multiplier.

---
 rtl/interp_gain_ramp_if.sv | 29 ++
 rtl/interp_gain_ramp.sv | 135 +++++++++++++
 tb/tb_interp_gain_ramp.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/interp_gain_ramp_if.sv
// Gain-ramp control bus between the interpolator register block (master)
// and the gain ramp sequencer (slave).
interface interp_gain_ramp_if #(
  parameter int MANT_WIDTH  = 18,
  parameter int EXP_WIDTH   = 5,
  parameter int STEP_WIDTH  = 8,
  parameter int DWELL_WIDTH = 8
);
  logic                   clkEn;
  logic                   update;
  logic [MANT_WIDTH-1:0]  targetMantissa;
  logic [EXP_WIDTH-1:0]   targetExponent;
  logic [STEP_WIDTH-1:0]  stepSize;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [MANT_WIDTH-1:0]  mantissa;
  logic [EXP_WIDTH-1:0]   exponent;
  logic                   busy;
  logic                   done;

  modport master (
    output clkEn, update, targetMantissa, targetExponent, stepSize, dwell,
    input  mantissa, exponent, busy, done
  );

  modport slave (
    input  clkEn, update, targetMantissa, targetExponent, stepSize, dwell,
    output mantissa, exponent, busy, done
  );
endinterface

// File: rtl/interp_gain_ramp.sv
// Gain ramp sequencer: steps the active mantissa toward a committed target,
// swapping the exponent only while the mantissa sits at zero.
module interp_gain_ramp #(
  parameter int MANT_WIDTH  = 18,
  parameter int EXP_WIDTH   = 5,
  parameter int STEP_WIDTH  = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  interp_gain_ramp_if.slave    gr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    SWAP      = 2'd2,
    RAMP      = 2'd3
  } state_t;

  state_t                 state_q;
  logic [MANT_WIDTH-1:0]  mant_q;
  logic [EXP_WIDTH-1:0]   exp_q;
  logic [MANT_WIDTH-1:0]  tgt_m_q;
  logic [EXP_WIDTH-1:0]   tgt_e_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q;
  logic                   done_q;

  logic                   step_s;
  logic [MANT_WIDTH-1:0]  step_ext_s;
  logic [MANT_WIDTH:0]    diff_s;
  logic [MANT_WIDTH-1:0]  down_d;
  logic [MANT_WIDTH-1:0]  ramp_d;

  // Step qualifier and the next mantissa for each ramp direction
  always_comb begin
    step_s     = gr.clkEn && (dwell_cnt_q == gr.dwell);
    step_ext_s = {{(MANT_WIDTH-STEP_WIDTH){1'b0}}, gr.stepSize};
    down_d     = (mant_q <= step_ext_s) ? '0 : (mant_q - step_ext_s);
    // The difference is one bit wider so the clamp test can never wrap
    if (tgt_m_q >= mant_q) begin
      diff_s = {1'b0, tgt_m_q} - {1'b0, mant_q};
      if (diff_s <= {1'b0, step_ext_s}) begin
        ramp_d = tgt_m_q;
      end else begin
        ramp_d = mant_q + step_ext_s;
      end
    end else begin
      diff_s = {1'b0, mant_q} - {1'b0, tgt_m_q};
      if (diff_s <= {1'b0, step_ext_s}) begin
        ramp_d = tgt_m_q;
      end else begin
        ramp_d = mant_q - step_ext_s;
      end
    end
  end

  // Sequencer state, active gain and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      tgt_m_q     <= '0;
      tgt_e_q     <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      // done reflects the RAMP->IDLE decision even if an update lands on it
      done_q <= (state_q == RAMP) && (mant_q == tgt_m_q);
      if (gr.update) begin
        tgt_m_q     <= gr.targetMantissa;
        tgt_e_q     <= gr.targetExponent;
        dwell_cnt_q <= '0;
        state_q     <= (gr.targetExponent != exp_q) ? RAMP_DOWN : RAMP;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          RAMP_DOWN: begin
            if (step_s) begin
              dwell_cnt_q <= '0;
            end else if (gr.clkEn) begin
              dwell_cnt_q <= dwell_cnt_q + 1'b1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q;
            end
            if (mant_q == '0) begin
              state_q <= SWAP;
            end else if (gr.stepSize == '0) begin
              mant_q <= '0;
            end else if (step_s) begin
              mant_q <= down_d;
            end else begin
              mant_q <= mant_q;
            end
          end
          SWAP: begin
            exp_q       <= tgt_e_q;
            dwell_cnt_q <= '0;
            state_q     <= RAMP;
          end
          RAMP: begin
            if (step_s) begin
              dwell_cnt_q <= '0;
            end else if (gr.clkEn) begin
              dwell_cnt_q <= dwell_cnt_q + 1'b1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q;
            end
            if (mant_q == tgt_m_q) begin
              state_q <= IDLE;
            end else if (gr.stepSize == '0) begin
              mant_q <= tgt_m_q;
            end else if (step_s) begin
              mant_q <= ramp_d;
            end else begin
              mant_q <= mant_q;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign gr.mantissa = mant_q;
  assign gr.exponent = exp_q;
  assign gr.busy     = (state_q != IDLE);
  assign gr.done     = done_q;

endmodule

// File: tb/tb_interp_gain_ramp.sv
// Directed bench for interp_gain_ramp: hand-computed mantissa/exponent
// sequences for each ramp scenario, sampled 1 ns after the rising edge.
module tb_interp_gain_ramp;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  interp_gain_ramp_if #(.MANT_WIDTH(18), .EXP_WIDTH(5), .STEP_WIDTH(8), .DWELL_WIDTH(8)) gr ();

  interp_gain_ramp #(.MANT_WIDTH(18), .EXP_WIDTH(5), .STEP_WIDTH(8), .DWELL_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gr      (gr.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [17:0] m, input logic [4:0] e);
    gr.targetMantissa = m;
    gr.targetExponent = e;
    gr.update = 1'b1;
    tick();
    gr.update = 1'b0;
  endtask

  task automatic chk_gain(input string tag, input logic [17:0] m, input logic [4:0] e);
    check_val({tag, ".mant"}, {14'd0, gr.mantissa}, {14'd0, m});
    check_val({tag, ".exp"}, {27'd0, gr.exponent}, {27'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] seq3 [8];
    logic [17:0] seq4 [5];
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    gr.clkEn = 1'b0;
    gr.update = 1'b0;
    gr.targetMantissa = 18'd0;
    gr.targetExponent = 5'd0;
    gr.stepSize = 8'd0;
    gr.dwell = 8'd0;
    tick();
    tick();
    chk_gain("rst", 18'd0, 5'd0);
    check_val("rst.busy", {31'd0, gr.busy}, 32'd0);
    check_val("rst.done", {31'd0, gr.done}, 32'd0);
    reset_n = 1'b1;

    // Scenario 1: ramp up from zero with an exponent swap
    gr.stepSize = 8'h40;
    gr.dwell = 8'd0;
    gr.clkEn = 1'b1;
    upd(18'h100, 5'd3);
    chk_gain("s1.cap", 18'd0, 5'd0);
    check_val("s1.busy", {31'd0, gr.busy}, 32'd1);
    tick();
    chk_gain("s1.rd", 18'd0, 5'd0);
    tick();
    chk_gain("s1.swap", 18'd0, 5'd3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_gain($sformatf("s1.step%0d", i), 18'(i * 'h40), 5'd3);
      check_val($sformatf("s1.nodone%0d", i), {31'd0, gr.done}, 32'd0);
    end
    tick();
    check_val("s1.done", {31'd0, gr.done}, 32'd1);
    check_val("s1.busy_end", {31'd0, gr.busy}, 32'd0);
    tick();
    check_val("s1.done_clr", {31'd0, gr.done}, 32'd0);

    // Scenario 2: clamp to a nearby target with dwell=2, clkEn every 4th cycle
    gr.clkEn = 1'b0;
    gr.dwell = 8'd2;
    upd(18'h0F0, 5'd3);
    for (int i = 0; i < 12; i++) begin
      gr.clkEn = ((i % 4) == 3);
      tick();
      chk_gain($sformatf("s2.c%0d", i), (i >= 11) ? 18'h0F0 : 18'h100, 5'd3);
    end
    gr.clkEn = 1'b0;
    tick();
    check_val("s2.done", {31'd0, gr.done}, 32'd1);
    check_val("s2.busy", {31'd0, gr.busy}, 32'd0);

    // Back to 0x100 with an immediate jump
    gr.stepSize = 8'd0;
    gr.dwell = 8'd0;
    upd(18'h100, 5'd3);
    tick();
    chk_gain("jump.mant", 18'h100, 5'd3);
    tick();
    check_val("jump.done", {31'd0, gr.done}, 32'd1);

    // Scenario 3: exponent change with down-ramp through zero
    seq3 = '{18'h0A0, 18'h040, 18'h000, 18'h000, 18'h000, 18'h060, 18'h080, 18'h080};
    gr.stepSize = 8'h60;
    gr.clkEn = 1'b1;
    upd(18'h080, 5'd5);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_gain($sformatf("s3.c%0d", i), seq3[i], (i >= 4) ? 5'd5 : 5'd3);
    end
    check_val("s3.done", {31'd0, gr.done}, 32'd1);

    // Set up exponent 3 at 0x100 again, then start a down-ramp toward exponent 5
    gr.stepSize = 8'd0;
    upd(18'h100, 5'd3);
    for (int i = 0; i < 4; i++) tick();
    chk_gain("s4.setup", 18'h100, 5'd3);
    gr.stepSize = 8'h60;
    upd(18'h010, 5'd5);
    tick();
    chk_gain("s4.mid", 18'h0A0, 5'd3);
    // Scenario 4: retarget to the active exponent mid RAMP_DOWN
    upd(18'h200, 5'd3);
    chk_gain("s4.cap", 18'h0A0, 5'd3);
    seq4 = '{18'h100, 18'h160, 18'h1C0, 18'h200, 18'h200};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_gain($sformatf("s4.c%0d", i), seq4[i], 5'd3);
    end
    check_val("s4.done", {31'd0, gr.done}, 32'd1);

    // Scenario 5: stepSize=0 jump to full scale without clkEn
    gr.clkEn = 1'b0;
    gr.stepSize = 8'd0;
    upd(18'h3FFFF, 5'd3);
    chk_gain("s5.cap", 18'h200, 5'd3);
    tick();
    chk_gain("s5.jump", 18'h3FFFF, 5'd3);
    tick();
    check_val("s5.done", {31'd0, gr.done}, 32'd1);
    check_val("s5.busy", {31'd0, gr.busy}, 32'd0);

    // Scenario 6: reset in the middle of a down-ramp
    gr.stepSize = 8'h40;
    gr.clkEn = 1'b1;
    upd(18'h100, 5'd3);
    tick();
    chk_gain("s6.pre", 18'h3FFBF, 5'd3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_gain("s6.rst", 18'd0, 5'd0);
    check_val("s6.busy", {31'd0, gr.busy}, 32'd0);
    check_val("s6.done", {31'd0, gr.done}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_gain("s6.idle", 18'd0, 5'd0);
    check_val("s6.idle_busy", {31'd0, gr.busy}, 32'd0);

    // Update equal to the active gain: done two cycles after update
    upd(18'd0, 5'd0);
    check_val("eq.busy", {31'd0, gr.busy}, 32'd1);
    check_val("eq.nodone", {31'd0, gr.done}, 32'd0);
    tick();
    check_val("eq.done", {31'd0, gr.done}, 32'd1);
    chk_gain("eq.gain", 18'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
